// File: rtl/running_minmax_if.sv
// Stream interface for running_minmax: sample input channel plus frame-result channel.
// Index outputs exist only when RUNNING_MINMAX_INDEX_EN is defined.
interface running_minmax_if #(
    parameter int unsigned N  = 32,
    parameter int unsigned CW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_min;
    logic [N-1:0]  out_max;
    logic [CW-1:0] out_count;
`ifdef RUNNING_MINMAX_INDEX_EN
    logic [CW-1:0] out_min_idx;
    logic [CW-1:0] out_max_idx;
`endif

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_min, out_max, out_count
`ifdef RUNNING_MINMAX_INDEX_EN
        , input out_min_idx, out_max_idx
`endif
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_min, out_max, out_count
`ifdef RUNNING_MINMAX_INDEX_EN
        , output out_min_idx, out_max_idx
`endif
    );
endinterface

// File: rtl/running_minmax.sv
// Per-frame signed min/max/count tracker with a one-result holding stage.
// Optional feature macro: RUNNING_MINMAX_INDEX_EN adds min/max position outputs.
module running_minmax #(
    parameter int unsigned N  = 32,
    parameter int unsigned CW = 16
) (
    input logic              clk,
    input logic              rst_n,
    running_minmax_if.slave  bus
);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t               state_q, state_d;
    logic signed [N-1:0]  min_q, min_d;
    logic signed [N-1:0]  max_q, max_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 accept;
`ifdef RUNNING_MINMAX_INDEX_EN
    logic [CW-1:0]        min_idx_q, min_idx_d;
    logic [CW-1:0]        max_idx_q, max_idx_d;
`endif

    assign accept = bus.in_valid & in_ready_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            min_q       <= '0;
            max_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef RUNNING_MINMAX_INDEX_EN
            min_idx_q   <= '0;
            max_idx_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            min_q       <= min_d;
            max_q       <= max_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef RUNNING_MINMAX_INDEX_EN
            min_idx_q   <= min_idx_d;
            max_idx_q   <= max_idx_d;
`endif
        end
    end

    // Next-state and datapath update; strict compares keep the first occurrence
    always_comb begin
        state_d   = state_q;
        min_d     = min_q;
        max_d     = max_q;
        cnt_d     = cnt_q;
`ifdef RUNNING_MINMAX_INDEX_EN
        min_idx_d = min_idx_q;
        max_idx_d = max_idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    min_d   = bus.in_data;
                    max_d   = bus.in_data;
                    cnt_d   = CW'(1);
`ifdef RUNNING_MINMAX_INDEX_EN
                    min_idx_d = '0;
                    max_idx_d = '0;
`endif
                    state_d = bus.in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    if ($signed(bus.in_data) < min_q) begin
                        min_d = bus.in_data;
`ifdef RUNNING_MINMAX_INDEX_EN
                        min_idx_d = cnt_q;
`endif
                    end
                    if (max_q < $signed(bus.in_data)) begin
                        max_d = bus.in_data;
`ifdef RUNNING_MINMAX_INDEX_EN
                        max_idx_d = cnt_q;
`endif
                    end
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (bus.in_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d != HOLD);
        out_valid_d = (state_d == HOLD);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_min   = min_q;
    assign bus.out_max   = max_q;
    assign bus.out_count = cnt_q;
`ifdef RUNNING_MINMAX_INDEX_EN
    assign bus.out_min_idx = min_idx_q;
    assign bus.out_max_idx = max_idx_q;
`endif
endmodule

// File: tb/tb_running_minmax.sv
// Directed bench for running_minmax: a CW=16 instance and a CW=2 instance share one stimulus.
module tb_running_minmax;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_ready;
    int          total;
    int          bad;

    running_minmax_if #(.N(32), .CW(16)) b0 ();
    running_minmax_if #(.N(32), .CW(2))  b1 ();

    assign b0.in_valid  = in_valid;
    assign b0.in_data   = in_data;
    assign b0.in_last   = in_last;
    assign b0.out_ready = out_ready;
    assign b1.in_valid  = in_valid;
    assign b1.in_data   = in_data;
    assign b1.in_last   = in_last;
    assign b1.out_ready = out_ready;

    running_minmax #(.N(32), .CW(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    running_minmax #(.N(32), .CW(2)) u_dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample after 'gap' idle cycles carrying junk; returns 1 time unit after the accept edge
    task automatic send(input logic [31:0] d, input logic last, input int gap);
        int waits;
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            in_last  = 1'b1;
            tick();
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        waits = 0;
        while (!b0.in_ready && waits < 20) begin
            tick();
            waits++;
        end
        check("in_ready", 32'(b0.in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic take_result(input string tag, input logic [31:0] mn, input logic [31:0] mx,
                               input logic [31:0] cnt, input logic [31:0] imn, input logic [31:0] imx);
        check({tag, ".vld"}, 32'(b0.out_valid), 32'd1);
        check({tag, ".min"}, b0.out_min, mn);
        check({tag, ".max"}, b0.out_max, mx);
        check({tag, ".cnt"}, 32'(b0.out_count), cnt);
`ifdef RUNNING_MINMAX_INDEX_EN
        check({tag, ".imin"}, 32'(b0.out_min_idx), imn);
        check({tag, ".imax"}, 32'(b0.out_max_idx), imx);
`else
        if (imn == 32'hFFFF_FFFF && imx == 32'hFFFF_FFFF) $display("no index: %s", tag);
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".vld_clr"}, 32'(b0.out_valid), 32'd0);
        check({tag, ".rdy_back"}, 32'(b0.in_ready), 32'd1);
    endtask

    logic [31:0] held_min;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst.rdy", 32'(b0.in_ready), 32'd0);
        check("rst.vld", 32'(b0.out_valid), 32'd0);
        check("rst.min", b0.out_min, 32'd0);
        check("rst.max", b0.out_max, 32'd0);
        check("rst.cnt", 32'(b0.out_count), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst.rdy_up", 32'(b0.in_ready), 32'd1);

        // Mixed frame with duplicate minimum
        send(32'd5, 1'b0, 0);
        send(32'hFFFF_FFFD, 1'b0, 0);
        send(32'd12, 1'b0, 0);
        send(32'hFFFF_FFFD, 1'b0, 0);
        send(32'd7, 1'b1, 0);
        check("f1.lat", 32'(b0.out_valid), 32'd1);
        check("f1.rdy_hold", 32'(b0.in_ready), 32'd0);
        take_result("f1", 32'hFFFF_FFFD, 32'd12, 32'd5, 32'd1, 32'd2);

        // Signed extremes that break an unsigned compare
        send(32'h7FFF_FFFF, 1'b0, 0);
        send(32'h8000_0000, 1'b1, 0);
        take_result("ovf", 32'h8000_0000, 32'h7FFF_FFFF, 32'd2, 32'd1, 32'd0);

        // All-negative frame, repeated minimum at the end
        send(32'hFFFF_FFFB, 1'b0, 0);
        send(32'hFFFF_FFF7, 1'b0, 0);
        send(32'hFFFF_FFFE, 1'b0, 0);
        send(32'hFFFF_FFF7, 1'b1, 0);
        take_result("neg", 32'hFFFF_FFF7, 32'hFFFF_FFFE, 32'd4, 32'd1, 32'd2);

        // Single-sample frame, then back-pressure for 10 cycles with a sample waiting
        send(32'hFFFF_FFFF, 1'b1, 0);
        check("one.lat", 32'(b0.out_valid), 32'd1);
        held_min = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        in_data  = 32'd99;
        in_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp.rdy", 32'(b0.in_ready), 32'd0);
            check("bp.vld", 32'(b0.out_valid), 32'd1);
            check("bp.min", b0.out_min, held_min);
            check("bp.max", b0.out_max, 32'hFFFF_FFFF);
            check("bp.cnt", 32'(b0.out_count), 32'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        take_result("one", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
        send(32'hFFFF_FFF9, 1'b1, 0);
        take_result("after_bp", 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd1, 32'd0, 32'd0);

        // Reset in the middle of a frame discards it
        send(32'd5, 1'b0, 0);
        send(32'd6, 1'b0, 0);
        send(32'd7, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        check("mrst.vld", 32'(b0.out_valid), 32'd0);
        check("mrst.rdy", 32'(b0.in_ready), 32'd0);
        check("mrst.cnt", 32'(b0.out_count), 32'd0);
        check("mrst.min", b0.out_min, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mrst.rdy_up", 32'(b0.in_ready), 32'd1);
        tick();
        tick();
        check("mrst.no_out", 32'(b0.out_valid), 32'd0);
        send(32'd4, 1'b0, 0);
        send(32'd2, 1'b1, 0);
        take_result("post_rst", 32'd2, 32'd4, 32'd2, 32'd1, 32'd0);

        // Saturating count on the CW=2 instance, with idle gaps carrying junk
        send(32'd1, 1'b0, 2);
        send(32'd2, 1'b0, 1);
        send(32'd3, 1'b0, 3);
        send(32'd4, 1'b0, 0);
        send(32'd5, 1'b1, 2);
        check("sat.vld", 32'(b1.out_valid), 32'd1);
        check("sat.cnt", 32'(b1.out_count), 32'd3);
        check("sat.max", b1.out_max, 32'd5);
        check("sat.min", b1.out_min, 32'd1);
`ifdef RUNNING_MINMAX_INDEX_EN
        check("sat.imax", 32'(b1.out_max_idx), 32'd3);
        check("sat.imin", 32'(b1.out_min_idx), 32'd0);
`endif
        take_result("gap", 32'd1, 32'd5, 32'd5, 32'd0, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
